jpeg_byte_packer_wr: RTL and testbench

- Upstream write stage for a 1024x32 single-port data memory in the JPEG MPSoC.
- Accepts the encoder's 8-bit output byte stream and packs it into 32-bit words.
- Writes each word through an Avalon-MM master port (byteenable-capable) at consecutive word addresses.
- Reports completion, words written and overflow to the controlling CPU.

---
 rtl/jpeg_byte_packer_wr.sv | 235 +++++++++++++++++++++++
 tb/tb_jpeg_byte_packer_wr.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_byte_packer_wr.sv
// Packs an 8-bit encoder byte stream into 32-bit words and writes them to word memory over Avalon-MM.
// Optional feature: define BYTE_SWAP_EN for big-endian lane packing (byte 0 in [31:24]).
module jpeg_byte_packer_wr #(
    parameter int ADDR_W    = 10,
    parameter int MEM_WORDS = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   max_words,
    output logic              busy,
    output logic              done,
    output logic              overflow,
    output logic [ADDR_W:0]   word_count,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [ADDR_W-1:0] m_address,
    output logic              m_chipselect,
    output logic              m_write,
    output logic [3:0]        m_byteenable,
    output logic [31:0]       m_writedata,
    output logic              m_clken,
    input  logic              m_waitrequest
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PACK  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [ADDR_W-1:0]   addr_r;
    logic [ADDR_W-1:0]   addr_inc_s;
    logic [ADDR_W:0]     budget_r;
    logic [ADDR_W:0]     word_count_r;
    logic [ADDR_W:0]     word_inc_s;
    logic [1:0]          byte_cnt_r;
    logic [1:0]          lane_s;
    logic [31:0]         pack_r;
    logic [31:0]         pack_nxt_s;
    logic                last_r;
    logic                accept_s;
    logic                complete_s;
    logic                busy_r;
    logic                done_r;
    logic                overflow_r;
    logic                in_ready_r;
    logic                m_chipselect_r;
    logic                m_write_r;
    logic [ADDR_W-1:0]   m_address_r;
    logic [3:0]          m_byteenable_r;
    logic [31:0]         m_writedata_r;

    // Lane enables for a word whose final collected byte sat at index last_idx.
    function automatic logic [3:0] lane_enables(input logic [1:0] last_idx);
        logic [3:0] be;
        case (last_idx)
`ifdef BYTE_SWAP_EN
            2'd0:    be = 4'b1000;
            2'd1:    be = 4'b1100;
            2'd2:    be = 4'b1110;
`else
            2'd0:    be = 4'b0001;
            2'd1:    be = 4'b0011;
            2'd2:    be = 4'b0111;
`endif
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // Lane selection, pack-register update and counter increments.
    always_comb begin
`ifdef BYTE_SWAP_EN
        lane_s = 2'd3 - byte_cnt_r;
`else
        lane_s = byte_cnt_r;
`endif
        pack_nxt_s               = pack_r;
        pack_nxt_s[8*lane_s +: 8] = in_data;
        word_inc_s = word_count_r + {{ADDR_W{1'b0}}, 1'b1};
        if (addr_r == ADDR_W'(MEM_WORDS - 1)) begin
            addr_inc_s = '0;
        end else begin
            addr_inc_s = addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

    // Next-state logic and byte-accept / write-complete strobes.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        complete_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_nxt_s = PACK;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PACK: begin
                if (in_valid && in_ready_r) begin
                    accept_s = 1'b1;
                    if (in_last || (byte_cnt_r == 2'd3)) begin
                        state_nxt_s = WRITE;
                    end else begin
                        state_nxt_s = PACK;
                    end
                end else begin
                    state_nxt_s = PACK;
                end
            end
            WRITE: begin
                if (!m_waitrequest) begin
                    complete_s = 1'b1;
                    if (last_r || (word_inc_s == budget_r)) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = PACK;
                    end
                end else begin
                    state_nxt_s = WRITE;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Job context: address, budget, word count and the partially packed word.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_r       <= '0;
            budget_r     <= '0;
            word_count_r <= '0;
            byte_cnt_r   <= 2'd0;
            pack_r       <= 32'd0;
            last_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        addr_r       <= base_addr;
                        budget_r     <= (max_words == '0) ? (ADDR_W+1)'(MEM_WORDS) : max_words;
                        word_count_r <= '0;
                        byte_cnt_r   <= 2'd0;
                        pack_r       <= 32'd0;
                        last_r       <= 1'b0;
                    end
                end
                PACK: begin
                    if (accept_s) begin
                        pack_r     <= pack_nxt_s;
                        byte_cnt_r <= byte_cnt_r + 2'd1;
                        last_r     <= in_last;
                    end
                end
                WRITE: begin
                    if (complete_s) begin
                        word_count_r <= word_inc_s;
                        addr_r       <= addr_inc_s;
                        byte_cnt_r   <= 2'd0;
                        pack_r       <= 32'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Registered status and Avalon master outputs; the word is captured as it enters WRITE and then held.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            overflow_r     <= 1'b0;
            in_ready_r     <= 1'b0;
            m_chipselect_r <= 1'b0;
            m_write_r      <= 1'b0;
            m_address_r    <= '0;
            m_byteenable_r <= 4'd0;
            m_writedata_r  <= 32'd0;
        end else begin
            busy_r         <= (state_nxt_s != IDLE);
            done_r         <= (state_nxt_s == DONE);
            in_ready_r     <= (state_nxt_s == PACK);
            m_chipselect_r <= (state_nxt_s == WRITE);
            m_write_r      <= (state_nxt_s == WRITE);
            if ((state_r == PACK) && (state_nxt_s == WRITE)) begin
                m_address_r    <= addr_r;
                m_writedata_r  <= pack_nxt_s;
                m_byteenable_r <= lane_enables(byte_cnt_r);
            end
            if ((state_r == IDLE) && start) begin
                overflow_r <= 1'b0;
            end else if (complete_s && !last_r && (word_inc_s == budget_r)) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign busy         = busy_r;
    assign done         = done_r;
    assign overflow     = overflow_r;
    assign word_count   = word_count_r;
    assign in_ready     = in_ready_r;
    assign m_address    = m_address_r;
    assign m_chipselect = m_chipselect_r;
    assign m_write      = m_write_r;
    assign m_byteenable = m_byteenable_r;
    assign m_writedata  = m_writedata_r;
    assign m_clken      = 1'b1;

endmodule

// File: tb/tb_jpeg_byte_packer_wr.sv
// Self-checking bench for jpeg_byte_packer_wr: job table, reference packer feeding a write scoreboard.
module tb_jpeg_byte_packer_wr;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [9:0]  base_addr;
    logic [10:0] max_words;
    logic        busy, done, overflow, in_ready;
    logic [10:0] word_count;
    logic [7:0]  in_data;
    logic        in_valid, in_last;
    logic [9:0]  m_address;
    logic        m_chipselect, m_write, m_clken;
    logic [3:0]  m_byteenable;
    logic [31:0] m_writedata;
    logic        m_waitrequest;

    jpeg_byte_packer_wr dut (
        .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
        .max_words(max_words), .busy(busy), .done(done), .overflow(overflow),
        .word_count(word_count), .in_data(in_data), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .m_address(m_address),
        .m_chipselect(m_chipselect), .m_write(m_write), .m_byteenable(m_byteenable),
        .m_writedata(m_writedata), .m_clken(m_clken), .m_waitrequest(m_waitrequest)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0]  a;
        logic [31:0] d;
        logic [3:0]  be;
    } wr_t;

    typedef struct {
        logic [9:0]  base;
        logic [10:0] maxw;
        int          nbytes;
        int          last_idx;
        logic [7:0]  seed;
        logic [7:0]  step;
        bit          wait_first;
        int          exp_words;
        bit          exp_ovf;
        wr_t         first_wr;
        wr_t         last_wr;
    } job_t;

    job_t jobs[6];
    wr_t  exp_q[$];

    int   checks = 0;
    int   errors = 0;

    // write/done monitor state
    wr_t         got_w, exp_w, first_w, last_w, snap_w;
    int          n_wr;
    int          done_cnt = 0;
    logic [10:0] wc_at_done;
    logic        ovf_at_done;
    logic        done_prev = 1'b0;

    // reference packer
    logic [31:0] mdl_word;
    logic [3:0]  mdl_be;
    int          mdl_n;
    logic [9:0]  mdl_addr;
    int          mdl_cnt, mdl_budget;
    bit          mdl_stop;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    // Scoreboard compare of every completed write, plus done-pulse bookkeeping.
    always @(negedge clk) begin
        if (reset_n && m_write && m_chipselect && !m_waitrequest) begin
            got_w = '{a: m_address, d: m_writedata, be: m_byteenable};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL write_unexpected: got a=%h d=%h be=%b required no write", got_w.a, got_w.d, got_w.be);
            end else begin
                exp_w = exp_q.pop_front();
                if (got_w !== exp_w) begin
                    errors++;
                    $display("FAIL write_data: got a=%h d=%h be=%b required a=%h d=%h be=%b",
                             got_w.a, got_w.d, got_w.be, exp_w.a, exp_w.d, exp_w.be);
                end
            end
            if (n_wr == 0) first_w = got_w;
            last_w = got_w;
            n_wr++;
        end
        if (reset_n && done) begin
            chk("busy_with_done", {63'd0, busy}, 64'd1);
            chk("done_width", {63'd0, done_prev}, 64'd0);
            done_cnt++;
            wc_at_done  = word_count;
            ovf_at_done = overflow;
        end
        done_prev = done;
    end

    task automatic model_byte(input logic [7:0] b, input bit last);
        int lane;
`ifdef BYTE_SWAP_EN
        lane = 3 - mdl_n;
`else
        lane = mdl_n;
`endif
        mdl_word[8*lane +: 8] = b;
        mdl_be[lane] = 1'b1;
        mdl_n++;
        if (mdl_n == 4 || last) begin
            exp_q.push_back('{a: mdl_addr, d: mdl_word, be: mdl_be});
            mdl_addr = (mdl_addr == 10'h3FF) ? 10'h000 : mdl_addr + 10'd1;
            mdl_cnt++;
            mdl_word = 32'd0;
            mdl_be   = 4'd0;
            mdl_n    = 0;
            if (!last && mdl_cnt == mdl_budget) mdl_stop = 1'b1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last, input int limit, output bit acc);
        in_data  = b;
        in_valid = 1'b1;
        in_last  = last;
        acc      = 1'b0;
        for (int t = 0; t < limit && !acc; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                acc = 1'b1;
            end
        end
    endtask

    task automatic pulse_start(input logic [9:0] b, input logic [10:0] m);
        @(posedge clk); #1;
        base_addr = b;
        max_words = m;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_job(input int idx);
        job_t       j;
        int         dc0;
        bit         acc, seen;
        logic [7:0] b;
        j = jobs[idx];
        m_waitrequest = j.wait_first;
        mdl_word = 32'd0; mdl_be = 4'd0; mdl_n = 0; mdl_addr = j.base;
        mdl_cnt = 0; mdl_budget = (j.maxw == 11'd0) ? 1024 : int'(j.maxw); mdl_stop = 1'b0;
        n_wr = 0;
        dc0  = done_cnt;
        pulse_start(j.base, j.maxw);
        fork
            begin
                for (int i = 0; i < j.nbytes; i++) begin
                    b = 8'(int'(j.seed) + int'(j.step) * i);
                    if (mdl_stop) begin
                        send_byte(b, (i == j.last_idx), 12, acc);
                        chk("byte_after_overflow_accepted", {63'd0, acc}, 64'd0);
                    end else begin
                        send_byte(b, (i == j.last_idx), 40, acc);
                        if (!acc) begin
                            checks++; errors++;
                            $display("FAIL byte_accept_timeout: got no accept of byte %0d required accept", i);
                        end else begin
                            model_byte(b, (i == j.last_idx));
                        end
                    end
                end
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            begin
                if (j.wait_first) begin
                    seen = 1'b0;
                    for (int t = 0; t < 60 && !seen; t++) begin
                        @(negedge clk);
                        if (m_write) seen = 1'b1;
                    end
                    chk("stall_write_seen", {63'd0, seen}, 64'd1);
                    snap_w = '{a: m_address, d: m_writedata, be: m_byteenable};
                    for (int k = 0; k < 3; k++) begin
                        if (k == 2) begin
                            @(posedge clk); #1;
                            m_waitrequest = 1'b0;
                        end
                        @(negedge clk);
                        chk("stall_hold", {m_write, m_chipselect, in_ready, word_count, m_address, m_writedata, m_byteenable},
                            {1'b1, 1'b1, 1'b0, 11'd0, snap_w.a, snap_w.d, snap_w.be});
                    end
                end
            end
        join
        for (int t = 0; t < 80 && done_cnt == dc0; t++) @(negedge clk);
        @(negedge clk);
        chk("done_pulses", 64'(done_cnt - dc0), 64'd1);
        chk("word_count", {53'd0, wc_at_done}, 64'(j.exp_words));
        chk("overflow", {63'd0, ovf_at_done}, {63'd0, j.exp_ovf});
        chk("writes_seen", 64'(n_wr), 64'(j.exp_words));
        chk("first_write", {18'd0, first_w}, {18'd0, j.first_wr});
        chk("last_write", {18'd0, last_w}, {18'd0, j.last_wr});
        chk("pending_expected", 64'(exp_q.size()), 64'd0);
        chk("idle_after_done", {62'd0, busy, done}, 64'd0);
        exp_q.delete();
    endtask

    task automatic chk_reset_state(input string name);
        chk(name, {busy, done, overflow, in_ready, m_chipselect, m_write, m_clken, m_address, m_byteenable, word_count},
            {6'd0, 1'b1, 10'd0, 4'd0, 11'd0});
        chk({name, "_wdata"}, {32'd0, m_writedata}, 64'd0);
    endtask

    initial begin
        bit acc;
`ifdef BYTE_SWAP_EN
        jobs[0] = '{10'h010, 11'd4, 6, 5, 8'h11, 8'h11, 1'b0, 2, 1'b0,
                    '{10'h010, 32'h11223344, 4'b1111}, '{10'h011, 32'h55660000, 4'b1100}};
        jobs[1] = '{10'h3FF, 11'd0, 8, 7, 8'h01, 8'h01, 1'b0, 2, 1'b0,
                    '{10'h3FF, 32'h01020304, 4'b1111}, '{10'h000, 32'h05060708, 4'b1111}};
        jobs[2] = '{10'h100, 11'd1, 6, -1, 8'h50, 8'h01, 1'b0, 1, 1'b1,
                    '{10'h100, 32'h50515253, 4'b1111}, '{10'h100, 32'h50515253, 4'b1111}};
        jobs[3] = '{10'h020, 11'd0, 4, 3, 8'h61, 8'h01, 1'b1, 1, 1'b0,
                    '{10'h020, 32'h61626364, 4'b1111}, '{10'h020, 32'h61626364, 4'b1111}};
        jobs[4] = '{10'h005, 11'd0, 3, 2, 8'hAA, 8'h11, 1'b0, 1, 1'b0,
                    '{10'h005, 32'hAABBCC00, 4'b1110}, '{10'h005, 32'hAABBCC00, 4'b1110}};
        jobs[5] = '{10'h040, 11'd0, 4, 3, 8'hA1, 8'h01, 1'b0, 1, 1'b0,
                    '{10'h040, 32'hA1A2A3A4, 4'b1111}, '{10'h040, 32'hA1A2A3A4, 4'b1111}};
`else
        jobs[0] = '{10'h010, 11'd4, 6, 5, 8'h11, 8'h11, 1'b0, 2, 1'b0,
                    '{10'h010, 32'h44332211, 4'b1111}, '{10'h011, 32'h00006655, 4'b0011}};
        jobs[1] = '{10'h3FF, 11'd0, 8, 7, 8'h01, 8'h01, 1'b0, 2, 1'b0,
                    '{10'h3FF, 32'h04030201, 4'b1111}, '{10'h000, 32'h08070605, 4'b1111}};
        jobs[2] = '{10'h100, 11'd1, 6, -1, 8'h50, 8'h01, 1'b0, 1, 1'b1,
                    '{10'h100, 32'h53525150, 4'b1111}, '{10'h100, 32'h53525150, 4'b1111}};
        jobs[3] = '{10'h020, 11'd0, 4, 3, 8'h61, 8'h01, 1'b1, 1, 1'b0,
                    '{10'h020, 32'h64636261, 4'b1111}, '{10'h020, 32'h64636261, 4'b1111}};
        jobs[4] = '{10'h005, 11'd0, 3, 2, 8'hAA, 8'h11, 1'b0, 1, 1'b0,
                    '{10'h005, 32'h00CCBBAA, 4'b0111}, '{10'h005, 32'h00CCBBAA, 4'b0111}};
        jobs[5] = '{10'h040, 11'd0, 4, 3, 8'hA1, 8'h01, 1'b0, 1, 1'b0,
                    '{10'h040, 32'hA4A3A2A1, 4'b1111}, '{10'h040, 32'hA4A3A2A1, 4'b1111}};
`endif
        reset_n = 1'b0; start = 1'b0; base_addr = 10'd0; max_words = 11'd0;
        in_data = 8'd0; in_valid = 1'b0; in_last = 1'b0; m_waitrequest = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_state("reset_state");
        reset_n = 1'b1;

        for (int i = 0; i < 5; i++) run_job(i);

        // reset in the middle of a word, then a clean job
        pulse_start(10'h200, 11'd0);
        send_byte(8'hEE, 1'b0, 40, acc);
        chk("pre_reset_accept0", {63'd0, acc}, 64'd1);
        send_byte(8'hFF, 1'b0, 40, acc);
        chk("pre_reset_accept1", {63'd0, acc}, 64'd1);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        @(posedge clk); #1;
        chk_reset_state("midjob_reset");
        reset_n = 1'b1;
        run_job(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1);
    end

endmodule
